// File: rtl/leitor_display.sv
// Reads a multiplexed 4-digit 7-segment display and commits one decoded frame once every digit has been captured.
// Latency: 2 sync + SETTLE settle + 1 commit cycles from the completing digit going stable to quadro_novo; no backpressure (the display cannot be stalled).
module leitor_display #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  d,
  input  logic [6:0]  seg,
  input  logic        ponto,
  output logic [15:0] dig_out,
  output logic [3:0]  ponto_out,
  output logic        quadro_novo,
  output logic        valido,
  output logic        erro,
  output logic        inativo
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW:0] SETTLE_LIM = (SW+1)'(SETTLE - 1);

  typedef enum logic [1:0] {SEM_SELECAO, ESTABILIZANDO, CAPTURADO} estado_t;

  estado_t        estado, estado_nxt;
  logic [3:0]     d_s1, d_s2;
  logic [6:0]     seg_s1, seg_s2, seg_prev;
  logic           ponto_s1, ponto_s2, ponto_prev;
  logic [1:0]     idx, idx_prev;
  logic           sel_vld, mudou, captura, commit, timeout_evt, has_e;
  logic [SW-1:0]  cnt, cnt_nxt;
  logic [SW:0]    cnt_inc;
  logic [TW-1:0]  idle_cnt;
  logic [3:0]     mask, cap_bit;
  logic [15:0]    shadow_dig;
  logic [3:0]     shadow_pt;

  function automatic logic [3:0] decod(input logic [6:0] s);
    case (s)
      7'b0000001: decod = 4'h0;
      7'b1001111: decod = 4'h1;
      7'b0010010: decod = 4'h2;
      7'b0000110: decod = 4'h3;
      7'b1001100: decod = 4'h4;
      7'b0100100: decod = 4'h5;
      7'b0100000: decod = 4'h6;
      7'b0001111: decod = 4'h7;
      7'b0000000: decod = 4'h8;
      7'b0000100: decod = 4'h9;
      7'b1111111: decod = 4'hF;
      default:    decod = 4'hE;
    endcase
  endfunction

  // Exactly one active-low enable selects a digit; the bit position is also its nibble slot.
  always_comb begin
    sel_vld = 1'b1;
    idx     = 2'd0;
    case (d_s2)
      4'b0111: idx = 2'd3;
      4'b1011: idx = 2'd2;
      4'b1101: idx = 2'd1;
      4'b1110: idx = 2'd0;
      default: sel_vld = 1'b0;
    endcase
  end

  assign mudou   = (idx != idx_prev) || (seg_s2 != seg_prev) || (ponto_s2 != ponto_prev);
  assign cnt_inc = {1'b0, cnt} + (SW+1)'(1);

  always_comb begin
    estado_nxt = estado;
    cnt_nxt    = cnt;
    captura    = 1'b0;
    case (estado)
      SEM_SELECAO: begin
        if (sel_vld) begin
          estado_nxt = ESTABILIZANDO;
          cnt_nxt    = '0;
        end
      end
      ESTABILIZANDO: begin
        if (!sel_vld) begin
          estado_nxt = SEM_SELECAO;
          cnt_nxt    = '0;
        end else if (mudou) begin
          cnt_nxt = '0;
        end else if (cnt_inc >= SETTLE_LIM) begin
          captura    = 1'b1;
          estado_nxt = CAPTURADO;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt_inc[SW-1:0];
        end
      end
      CAPTURADO: begin
        if (!sel_vld) begin
          estado_nxt = SEM_SELECAO;
        end else if (mudou) begin
          estado_nxt = ESTABILIZANDO;
          cnt_nxt    = '0;
        end
      end
      default: begin
        estado_nxt = SEM_SELECAO;
        cnt_nxt    = '0;
      end
    endcase
  end

  assign cap_bit     = captura ? (4'b0001 << idx) : 4'b0000;
  assign commit      = (mask == 4'b1111);
  // A capture in the same cycle pre-empts the timeout.
  assign timeout_evt = !captura && (idle_cnt == TW'(TIMEOUT - 1));
  assign has_e       = (shadow_dig[15:12] == 4'hE) || (shadow_dig[11:8] == 4'hE) ||
                       (shadow_dig[7:4] == 4'hE)   || (shadow_dig[3:0] == 4'hE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_s1        <= 4'hF;
      d_s2        <= 4'hF;
      seg_s1      <= 7'h7F;
      seg_s2      <= 7'h7F;
      ponto_s1    <= 1'b1;
      ponto_s2    <= 1'b1;
      seg_prev    <= 7'h7F;
      ponto_prev  <= 1'b1;
      idx_prev    <= 2'd0;
      estado      <= SEM_SELECAO;
      cnt         <= '0;
      idle_cnt    <= '0;
      mask        <= 4'b0000;
      shadow_dig  <= 16'hFFFF;
      shadow_pt   <= 4'b0000;
      dig_out     <= 16'hFFFF;
      ponto_out   <= 4'b0000;
      quadro_novo <= 1'b0;
      valido      <= 1'b0;
      erro        <= 1'b0;
      inativo     <= 1'b0;
    end else begin
      d_s1       <= d;
      d_s2       <= d_s1;
      seg_s1     <= seg;
      seg_s2     <= seg_s1;
      ponto_s1   <= ponto;
      ponto_s2   <= ponto_s1;
      seg_prev   <= seg_s2;
      ponto_prev <= ponto_s2;
      idx_prev   <= idx;
      estado     <= estado_nxt;
      cnt        <= cnt_nxt;
      quadro_novo <= commit;

      if (captura) begin
        shadow_dig[{idx, 2'b00} +: 4] <= decod(seg_s2);
        shadow_pt[idx]                <= ~ponto_s2;
      end

      if (commit || timeout_evt)
        mask <= cap_bit;
      else
        mask <= mask | cap_bit;

      if (commit) begin
        dig_out   <= shadow_dig;
        ponto_out <= shadow_pt;
        erro      <= has_e;
        valido    <= !has_e;
      end else if (timeout_evt) begin
        valido <= 1'b0;
      end

      if (captura) begin
        idle_cnt <= '0;
        inativo  <= 1'b0;
      end else if (idle_cnt != TW'(TIMEOUT)) begin
        idle_cnt <= idle_cnt + TW'(1);
        if (timeout_evt)
          inativo <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_leitor_display.sv
// Directed bench for leitor_display: frames, glitch rejection, illegal/blank codes, timeout and mid-frame reset.
module tb_leitor_display;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 300;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b0100000, S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0000100, SB = 7'b1111111, SX = 7'b0110110;
  localparam logic [3:0] D1 = 4'b0111, D2 = 4'b1011, D3 = 4'b1101, D4 = 4'b1110;

  logic        clk, rst_n;
  logic [3:0]  d;
  logic [6:0]  seg;
  logic        ponto;
  logic [15:0] dig_out;
  logic [3:0]  ponto_out;
  logic        quadro_novo, valido, erro, inativo;

  int n_assert = 0;
  int n_fail   = 0;
  int qn_count = 0;
  int qn_exp   = 0;

  leitor_display #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .seg(seg), .ponto(ponto),
    .dig_out(dig_out), .ponto_out(ponto_out), .quadro_novo(quadro_novo),
    .valido(valido), .erro(erro), .inativo(inativo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (quadro_novo === 1'b1) qn_count++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge and are held for n edges.
  task automatic show(input logic [3:0] dd, input logic [6:0] ss, input logic pp, input int n);
    d = dd; seg = ss; ponto = pp;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    show(4'hF, SB, 1'b1, n);
  endtask

  task automatic frame(input logic [6:0] a, b, c, e, input logic [3:0] pts);
    show(D1, a, pts[3], 8);
    show(D2, b, pts[2], 8);
    show(D3, c, pts[1], 8);
    show(D4, e, pts[0], 8);
    idle(4);
  endtask

  task automatic chk_status(input string tag, input logic [15:0] dig, input logic v, input logic e, input logic ina);
    chk({tag, "_dig"}, dig_out, dig);
    chk({tag, "_valido"}, {15'd0, valido}, {15'd0, v});
    chk({tag, "_erro"}, {15'd0, erro}, {15'd0, e});
    chk({tag, "_inativo"}, {15'd0, inativo}, {15'd0, ina});
    chk({tag, "_pulses"}, 16'(qn_count), 16'(qn_exp));
  endtask

  initial begin
    rst_n = 1'b0; d = 4'hF; seg = SB; ponto = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_status("reset", 16'hFFFF, 1'b0, 1'b0, 1'b0);
    chk("reset_ponto", {12'd0, ponto_out}, 16'h0000);
    chk("reset_qn", {15'd0, quadro_novo}, 16'h0000);
    rst_n = 1'b1;
    idle(4);

    // Frame "2024" with an exact latency check on the completing digit.
    show(D1, S2, 1'b1, 8);
    show(D2, S0, 1'b1, 8);
    show(D3, S2, 1'b1, 8);
    d = D4; seg = S4; ponto = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("lat_before", {15'd0, quadro_novo}, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    chk("lat_pulse", {15'd0, quadro_novo}, 16'h0001);
    chk("lat_dig", dig_out, 16'h2024);
    @(posedge clk);
    @(negedge clk);
    chk("lat_after", {15'd0, quadro_novo}, 16'h0000);
    @(posedge clk);
    #1;
    idle(4);
    qn_exp = 1;
    chk_status("f2024", 16'h2024, 1'b1, 1'b0, 1'b0);
    chk("f2024_ponto", {12'd0, ponto_out}, 16'h0000);

    // d2 glitches every 2 cycles: no d2 capture, so no commit after d3/d4.
    show(D1, S5, 1'b1, 8);
    for (int i = 0; i < 6; i++) begin
      show(D2, S6, 1'b1, 2);
      show(D2, S8, 1'b1, 2);
    end
    show(D3, S7, 1'b1, 8);
    show(D4, S9, 1'b1, 8);
    idle(4);
    chk_status("glitch_hold", 16'h2024, 1'b1, 1'b0, 1'b0);
    show(D2, S6, 1'b1, 8);
    idle(4);
    qn_exp++;
    chk_status("glitch_commit", 16'h5679, 1'b1, 1'b0, 1'b0);

    // Illegal pattern on d3.
    frame(S1, S2, SX, S3, 4'b1111);
    qn_exp++;
    chk_status("illegal", 16'h12E3, 1'b0, 1'b1, 1'b0);

    // Blank d1 with its point lit.
    frame(SB, S8, S0, S1, 4'b0111);
    qn_exp++;
    chk_status("blank", 16'hF801, 1'b1, 1'b0, 1'b0);
    chk("blank_ponto", {12'd0, ponto_out}, 16'h0008);

    // Timeout: still active shortly before TIMEOUT, inactive after.
    idle(200);
    chk("pre_timeout_inativo", {15'd0, inativo}, 16'h0000);
    chk("pre_timeout_valido", {15'd0, valido}, 16'h0001);
    idle(120);
    chk_status("timeout", 16'hF801, 1'b0, 1'b0, 1'b1);
    chk("timeout_ponto", {12'd0, ponto_out}, 16'h0008);
    show(D1, S2, 1'b1, 8);
    chk("recover_inativo", {15'd0, inativo}, 16'h0000);
    chk("recover_valido_pending", {15'd0, valido}, 16'h0000);
    show(D2, S0, 1'b1, 8);
    show(D3, S2, 1'b1, 8);
    show(D4, S4, 1'b1, 8);
    idle(4);
    qn_exp++;
    chk_status("recover", 16'h2024, 1'b1, 1'b0, 1'b0);

    // Reset after d1/d2 captures; partial frame must be discarded.
    show(D1, S7, 1'b1, 8);
    show(D2, S7, 1'b1, 8);
    d = 4'hF; seg = SB; ponto = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_status("midreset", 16'hFFFF, 1'b0, 1'b0, 1'b0);
    chk("midreset_ponto", {12'd0, ponto_out}, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    show(D3, S1, 1'b1, 8);
    show(D4, S2, 1'b1, 8);
    idle(4);
    chk_status("midreset_partial", 16'hFFFF, 1'b0, 1'b0, 1'b0);
    show(D1, S3, 1'b1, 8);
    show(D2, S4, 1'b1, 8);
    idle(4);
    qn_exp++;
    chk_status("midreset_commit", 16'h3412, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
